// File: rtl/word_packer.sv
// word_packer: splits a valid/ready byte stream on a delimiter and packs each
// token, first character in the most significant byte, into a fixed-width word
// for the downstream matcher. Each packed word is held until it is accepted.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     in_data / in_last valid
//   in_data      character byte
//   in_last      final byte of the stream
//   in_ready     byte accepted when in_valid && in_ready (high in FILL)
//   word         packed word, MSB-first, zero-padded in the low bytes
//   word_len     number of valid characters in word
//   word_full    word closed because WORD_LENGTH characters were stored
//   word_last    word closes the stream
//   word_valid   output word valid (high in HOLD)
//   word_ready   downstream accepts when word_valid && word_ready
module word_packer #(
    parameter int unsigned WORD_LENGTH = 3,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] DELIM = 8'h20
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_last,
    output logic                                 in_ready,
    output logic [WORD_LENGTH*DATA_WIDTH-1:0]    word,
    output logic [$clog2(WORD_LENGTH+1)-1:0]     word_len,
    output logic                                 word_full,
    output logic                                 word_last,
    output logic                                 word_valid,
    input  logic                                 word_ready
);

    localparam int unsigned WORD_W = WORD_LENGTH * DATA_WIDTH;
    localparam int unsigned LEN_W  = $clog2(WORD_LENGTH + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   count_n;
    logic [WORD_W-1:0]  word_n;
    logic [LEN_W-1:0]   len_n;
    logic               full_n;
    logic               last_n;
    logic               is_delim;

    // Handshake flags decode straight from the state register.
    assign in_ready   = (state == FILL);
    assign word_valid = (state == HOLD);

    assign is_delim = (in_data == DELIM);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers; reset drops any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            word      <= '0;
            word_len  <= '0;
            word_full <= 1'b0;
            word_last <= 1'b0;
        end else begin
            count     <= count_n;
            word      <= word_n;
            word_len  <= len_n;
            word_full <= full_n;
            word_last <= last_n;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        state_n = state;
        count_n = count;
        word_n  = word;
        len_n   = word_len;
        full_n  = word_full;
        last_n  = word_last;

        case (state)
            FILL: begin
                if (in_valid) begin
                    if (!is_delim) begin
                        // Slot 0 occupies the most significant byte.
                        for (int i = 0; i < int'(WORD_LENGTH); i++) begin
                            if (count == LEN_W'(i)) begin
                                word_n[(int'(WORD_LENGTH) - 1 - i) * int'(DATA_WIDTH) +: DATA_WIDTH] = in_data;
                            end
                        end
                        count_n = count + LEN_W'(1);
                        if (count_n == LEN_W'(WORD_LENGTH)) begin
                            state_n = HOLD;
                            full_n  = 1'b1;
                            last_n  = in_last;
                            len_n   = count_n;
                        end else if (in_last) begin
                            state_n = HOLD;
                            full_n  = 1'b0;
                            last_n  = 1'b1;
                            len_n   = count_n;
                        end
                    end else if (count != '0) begin
                        // Delimiter closes a non-empty token.
                        state_n = HOLD;
                        full_n  = 1'b0;
                        last_n  = in_last;
                        len_n   = count;
                    end else if (in_last) begin
                        // Empty word so that end of stream is always signalled.
                        state_n = HOLD;
                        word_n  = '0;
                        len_n   = '0;
                        full_n  = 1'b0;
                        last_n  = 1'b1;
                    end
                    // Delimiter with nothing stored and not last: dropped.
                end
            end

            HOLD: begin
                if (word_ready) begin
                    state_n = FILL;
                    count_n = '0;
                    word_n  = '0;
                    len_n   = '0;
                    full_n  = 1'b0;
                    last_n  = 1'b0;
                end
            end

            default: begin
                state_n = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_word_packer.sv
module tb_word_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic [23:0] word;
    logic [1:0]  word_len;
    logic        word_full;
    logic        word_last;
    logic        word_valid;
    logic        word_ready;

    int checks;
    int failures;

    // Words accepted by the downstream side.
    logic [23:0] wq[$];
    logic [1:0]  lq[$];
    logic        fq[$];
    logic        tq[$];
    bit          valid_seen;

    word_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .word       (word),
        .word_len   (word_len),
        .word_full  (word_full),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && word_valid) begin
            valid_seen = 1'b1;
            if (word_ready) begin
                wq.push_back(word);
                lq.push_back(word_len);
                fq.push_back(word_full);
                tq.push_back(word_last);
            end
        end
    end

    task automatic clear_q();
        wq.delete(); lq.delete(); fq.delete(); tq.delete();
        valid_seen = 1'b0;
    endtask

    // Present one byte and wait (bounded) until it is accepted.
    task automatic send(input logic [7:0] b, input logic last);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%h in_ready never rose", b);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_on_end);
        for (int i = 0; i < s.len(); i++) begin
            send(8'(s[i]), last_on_end && (i == s.len() - 1));
        end
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if ({word, word_len, word_full, word_last, word_valid} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs got word=%h len=%0d full=%b last=%b valid=%b exp all 0",
                     word, word_len, word_full, word_last, word_valid);
        end
    endtask

    task automatic test_hel();
        int zeros;
        clear_q();
        word_ready = 1'b1;
        send_str("Hel", 1'b1);
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (!in_ready) zeros++;
            @(posedge clk); #1;
        end
        checks++;
        if (zeros !== 1) begin failures++; $display("FAIL hel_ready_bubble got=%0d exp=1", zeros); end
        checks++;
        if (wq.size() !== 1) begin
            failures++; $display("FAIL hel_count got=%0d exp=1", wq.size());
        end else begin
            checks++;
            if ({wq[0], lq[0], fq[0], tq[0]} !== {24'h48656C, 2'd3, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL hel_word got=%h/%0d/%b/%b exp=48656c/3/1/1", wq[0], lq[0], fq[0], tq[0]);
            end
        end
    endtask

    task automatic test_hi_there();
        logic [23:0] ew[3];
        logic [1:0]  el[3];
        logic        ef[3];
        logic        et[3];
        ew = '{24'h486900, 24'h746865, 24'h726500};
        el = '{2'd2, 2'd3, 2'd2};
        ef = '{1'b0, 1'b1, 1'b0};
        et = '{1'b0, 1'b0, 1'b1};
        clear_q();
        word_ready = 1'b1;
        send_str("Hi there", 1'b1);
        drain();
        checks++;
        if (wq.size() !== 3) begin
            failures++; $display("FAIL hi_count got=%0d exp=3", wq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({wq[i], lq[i], fq[i], tq[i]} !== {ew[i], el[i], ef[i], et[i]}) begin
                    failures++;
                    $display("FAIL hi_word%0d got=%h/%0d/%b/%b exp=%h/%0d/%b/%b", i,
                             wq[i], lq[i], fq[i], tq[i], ew[i], el[i], ef[i], et[i]);
                end
            end
        end
    endtask

    task automatic test_double_delim();
        clear_q();
        word_ready = 1'b1;
        send_str("a  b", 1'b1);
        drain();
        checks++;
        if (wq.size() !== 2) begin
            failures++; $display("FAIL dd_count got=%0d exp=2", wq.size());
        end else begin
            checks++;
            if ({wq[0], lq[0], tq[0]} !== {24'h610000, 2'd1, 1'b0}) begin
                failures++; $display("FAIL dd_word0 got=%h/%0d/%b exp=610000/1/0", wq[0], lq[0], tq[0]);
            end
            checks++;
            if ({wq[1], lq[1], tq[1]} !== {24'h620000, 2'd1, 1'b1}) begin
                failures++; $display("FAIL dd_word1 got=%h/%0d/%b exp=620000/1/1", wq[1], lq[1], tq[1]);
            end
        end
    endtask

    task automatic test_trailing_delim();
        clear_q();
        word_ready = 1'b1;
        send_str("ab ", 1'b1);
        drain();
        checks++;
        if (wq.size() !== 1) begin
            failures++; $display("FAIL trail_count got=%0d exp=1", wq.size());
        end else begin
            checks++;
            if ({wq[0], lq[0], fq[0], tq[0]} !== {24'h616200, 2'd2, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL trail_word got=%h/%0d/%b/%b exp=616200/2/0/1", wq[0], lq[0], fq[0], tq[0]);
            end
        end
    endtask

    task automatic test_empty_last();
        clear_q();
        word_ready = 1'b1;
        send_str(" ", 1'b1);
        drain();
        checks++;
        if (wq.size() !== 1) begin
            failures++; $display("FAIL empty_count got=%0d exp=1", wq.size());
        end else begin
            checks++;
            if ({wq[0], lq[0], fq[0], tq[0]} !== {24'h000000, 2'd0, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL empty_word got=%h/%0d/%b/%b exp=000000/0/0/1", wq[0], lq[0], fq[0], tq[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit bad;
        clear_q();
        word_ready = 1'b0;
        send_str("Hel", 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({word_valid, in_ready, word, word_len, word_full, word_last} !==
                {1'b1, 1'b0, 24'h48656C, 2'd3, 1'b1, 1'b1}) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold got valid=%b ready=%b word=%h exp stable 48656c with in_ready=0",
                     word_valid, in_ready, word);
        end
        checks++;
        if (wq.size() !== 0) begin failures++; $display("FAIL bp_early_accept got=%0d exp=0", wq.size()); end
        word_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wq.size() !== 1 || word_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got n=%0d valid=%b in_ready=%b exp 1/0/1", wq.size(), word_valid, in_ready);
        end else begin
            checks++;
            if (wq[0] !== 24'h48656C) begin failures++; $display("FAIL bp_word got=%h exp=48656c", wq[0]); end
        end
    endtask

    task automatic test_reset_mid_word();
        clear_q();
        word_ready = 1'b1;
        send_str("He", 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({word, word_len, word_full, word_last, word_valid, in_ready} !== {29'd0, 1'b1}) begin
            failures++;
            $display("FAIL rstmid_outputs got word=%h len=%0d full=%b last=%b valid=%b in_ready=%b exp 0s, in_ready=1",
                     word, word_len, word_full, word_last, word_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_seen !== 1'b0 || wq.size() !== 0) begin
            failures++; $display("FAIL rstmid_no_word got valid_seen=%b n=%0d exp 0/0", valid_seen, wq.size());
        end
        send_str("xyz", 1'b0);
        drain();
        checks++;
        if (wq.size() !== 1) begin
            failures++; $display("FAIL rstmid_xyz_count got=%0d exp=1", wq.size());
        end else begin
            checks++;
            if ({wq[0], lq[0], fq[0], tq[0]} !== {24'h78797A, 2'd3, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL rstmid_xyz got=%h/%0d/%b/%b exp=78797a/3/1/0", wq[0], lq[0], fq[0], tq[0]);
            end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        valid_seen = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_hel();
        test_hi_there();
        test_double_delim();
        test_trailing_delim();
        test_empty_last();
        test_backpressure();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/word_packer.md
# word_packer

Front-end stage that feeds the vocabulary `matcher`. It accepts a byte stream (ASCII characters, one per cycle) over a valid/ready handshake and splits it on a delimiter byte. It packs each token into the fixed-width `word` bus the matcher consumes, holding each packed word until the matcher side accepts it. Packing is first character in the most significant byte, so "Hel" is presented as {8'h48, 8'h65, 8'h6C}.

## Interface
- `WORD_LENGTH`, 3, characters per packed word
- `DATA_WIDTH`, 8, bits per character
- `DELIM`, 8'h20, delimiter byte; consumed, never stored
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `in_data` / `in_last` valid
- `in_data`  in  DATA_WIDTH  character byte
- `in_last`  in  1  final byte of stream
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`
- `word`  out  WORD_LENGTH*DATA_WIDTH  packed word, MSB-first, zero-padded in low bytes
- `word_len`  out  $clog2(WORD_LENGTH+1)  valid characters in `word` (0..WORD_LENGTH)
- `word_full`  out  1  word closed because WORD_LENGTH was reached, not by delimiter or last
- `word_last`  out  1  word closes the stream
- `word_valid`  out  1  output word valid
- `word_ready`  in  1  downstream accepts when `word_valid && word_ready`

## Operation
- Two-state FSM: FILL (reset state) and HOLD.
- `in_ready` = (state == FILL). `word_valid` = (state == HOLD). Both are decoded from the state register only.
- Internal `count` holds characters stored in the current word. The buffer is held in the `word` register.
- The following rules apply to an accepted byte in FILL:
  - Non-delimiter: write to byte slot `count`. Slot 0 is bits [WORD_LENGTH*DATA_WIDTH-1 -: DATA_WIDTH]. Then `count`+1.
  - Non-delimiter with `count`+1 == WORD_LENGTH: go to HOLD with `word_full`=1 and `word_last`=`in_last`.
  - Non-delimiter with `in_last` and not full: go to HOLD with `word_full`=0 and `word_last`=1.
  - Delimiter with `count` > 0: go to HOLD with `word_full`=0 and `word_last`=`in_last`.
  - Delimiter with `count` == 0 and not `in_last`: discard the byte and stay in FILL. Consecutive delimiters produce no empty words.
  - Delimiter with `count` == 0 and `in_last`: go to HOLD with an empty word: `word`=0, `word_len`=0, `word_last`=1. This guarantees the end of stream is always signalled.
- On entering HOLD, `word_len` takes the final count.
- In HOLD, on `word_ready`, go to FILL on the next edge. At the same edge clear `word`, `count`, `word_len`, `word_full` and `word_last` to 0.
- Tokens longer than WORD_LENGTH are split into consecutive full chunks with `word_full`=1. The remainder follows as a normal word.
- All outputs hold stable while `word_valid`=1 and `word_ready`=0.

## Timing
- Reset (async, `rst_n`=0): state=FILL, `count`=0, `word`=0, `word_len`=0, `word_full`=0, `word_last`=0, `word_valid`=0.
- `in_ready` reads 1 during reset. Upstream must not drive `in_valid` while `rst_n`=0.
- Reset mid-word or in HOLD discards the partial or held word immediately, with no output.
- Latency: `word_valid` rises on the edge that accepts the closing byte.
- Minimum occupancy of HOLD is 1 cycle: `word_ready` held high gives `word_valid` for exactly one cycle.
- Throughput: one byte per cycle in FILL, plus one bubble cycle per emitted word.
- No combinational path from `in_valid` or `word_ready` to any output.

## Test plan
- Stream "Hel" with `in_last` on 'l' and `word_ready`=1.
  - Required: one word 24'h48656C, `word_len`=3, `word_full`=1, `word_last`=1.
  - `in_ready` is 0 for exactly one cycle.
- Stream "Hi there" (8 bytes, last on 'e') with `word_ready`=1.
  - Required: word 24'h486900 with `len`=2, `full`=0.
  - Then word 24'h746865 with `len`=3, `full`=1.
  - Then word 24'h726500 with `len`=2, `last`=1.
- Stream "a", space, space, "b" (last on 'b').
  - Required: exactly two words, 24'h610000 and 24'h620000 (`last`=1). No empty word.
- Stream "ab" followed by a trailing space carrying `in_last`.
  - Required: word 24'h616200 with `last`=1, `len`=2.
- Stream a single space carrying `in_last`.
  - Required: word 0, `len`=0, `last`=1.
- Backpressure: hold `word_ready`=0 for 5 cycles after "Hel".
  - Required: outputs stable and `in_ready`=0 throughout; the word accepted on the first `word_ready`=1 cycle.
- Reset mid-word: assert `rst_n`=0 after "He" is accepted.
  - Required: all outputs 0 and `word_valid` never asserted.
  - After release, "xyz" yields 24'h78797A.
